// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the execute-stage memory issuer.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [5:0] ECODE_ALE = 6'h9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CANCEL = 2'd3
  } mem_state_e;

  // Byte enables for an access of 2^size bytes starting at byte lane off.
  // Sized for the widest (64-bit) bus; narrower builds use the low lanes.
  function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Replicate the low 2^size bytes of wdata across the full 64-bit lane set.
  function automatic logic [63:0] wdata_rep(input logic [1:0] size, input logic [63:0] wdata);
    case (size)
      SZ_B:    return {8{wdata[7:0]}};
      SZ_H:    return {4{wdata[15:0]}};
      SZ_W:    return {2{wdata[31:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_outstanding_ctr.sv
// Saturating up/down counter; an increment and a decrement in the same
// cycle cancel out.
module mem_outstanding_ctr #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count, clamped to [0, MAX].
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != MAX_V) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/exe_mem_issue.sv
// Execute-stage memory-request issuer: computes address, strobes, write data
// and ALE, drives an SRAM-like addr_ok/data_ok bus, and tracks responses that
// belong to flushed requests.
//
// state  | meaning
// IDLE   | no op held
// ISSUE  | request presented (unless outstanding is full), waiting for addr_ok
// HOLD   | op offered to MEM (out_valid), waiting for out_allowin
// CANCEL | op flushed after its request was presented; waiting for addr_ok
module exe_mem_issue
  import mem_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_allowin,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [1:0]          in_size,
  input  logic [31:0]         in_base,
  input  logic [31:0]         in_offset,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_ex,
  input  logic                flush,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [31:0]         data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  output logic                data_drop,
  output logic                out_valid,
  input  logic                out_allowin,
  output logic [31:0]         out_addr,
  output logic                out_ale,
  output logic                out_mem_issued
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  mem_state_e          state_q, state_d;
  logic                store_q, store_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ale_q, ale_d;
  logic                issued_q, issued_d;

  logic [CNT_W-1:0]    outst_cnt, drop_cnt;
  logic                outst_full, accept, bus_ok, drop_inc;
  logic [31:0]         ea;
  logic [2:0]          ea_off, size_mask;
  logic [63:0]         wdata_ext, wrep64;
  logic [7:0]          strb8;
  logic                is_ls, ale_new, go_bus;
  logic                unused_lanes;

  // Decode the incoming op: effective address, alignment, lane data.
  always_comb begin
    ea = in_base + in_offset;
    ea_off = '0;
    ea_off[OFF_W-1:0] = ea[OFF_W-1:0];
    wdata_ext = '0;
    wdata_ext[DATA_W-1:0] = in_wdata;
    case (in_size)
      SZ_B:    size_mask = 3'b000;
      SZ_H:    size_mask = 3'b001;
      SZ_W:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
    is_ls   = in_load | in_store;
    ale_new = is_ls & ((|(ea[2:0] & size_mask)) | ((in_size == SZ_D) && (DATA_W == 32)));
    go_bus  = is_ls & ~ale_new & ~in_ex;
    strb8   = strb_gen(in_size, ea_off);
    wrep64  = wdata_rep(in_size, wdata_ext);
  end

  // Upper lanes only carry meaning on 64-bit builds.
  assign unused_lanes = ^{strb8, wrep64};

  // State-derived handshake outputs.
  always_comb begin
    outst_full = (outst_cnt == CNT_W'(MAX_OUTSTANDING));
    data_req   = ((state_q == ST_ISSUE) && !outst_full) || (state_q == ST_CANCEL);
    out_valid  = (state_q == ST_HOLD);
    in_allowin = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_allowin)) && !flush;
  end

  assign accept = in_valid & in_allowin;
  assign bus_ok = data_req & data_addr_ok;

  // Next state and op capture; flush outranks everything, and a request
  // already on the bus is never withdrawn.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    ale_d    = ale_q;
    issued_d = issued_q;
    drop_inc = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (flush) begin
          if (bus_ok) begin
            state_d  = ST_IDLE;
            drop_inc = 1'b1;
          end else if (data_req) begin
            state_d = ST_CANCEL;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus_ok) begin
          state_d  = ST_HOLD;
          issued_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush || out_allowin) state_d = ST_IDLE;
      end
      ST_CANCEL: begin
        if (bus_ok) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d  = go_bus ? ST_ISSUE : ST_HOLD;
      store_d  = in_store;
      size_d   = in_size;
      addr_d   = ea;
      wstrb_d  = (in_store && go_bus) ? strb8[STRB_W-1:0] : '0;
      wdata_d  = wrep64[DATA_W-1:0];
      ale_d    = ale_new;
      issued_d = 1'b0;
    end
  end

  // State and captured-op registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      ale_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      ale_q    <= ale_d;
      issued_q <= issued_d;
    end
  end

  assign data_wr        = store_q;
  assign data_size      = size_q;
  assign data_addr      = addr_q;
  assign data_wstrb     = data_req ? wstrb_q : '0;
  assign data_wdata     = wdata_q;
  assign data_drop      = data_data_ok & (drop_cnt != '0);
  assign out_addr       = addr_q;
  assign out_ale        = ale_q;
  assign out_mem_issued = issued_q;

  mem_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_outst_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (bus_ok),
    .dec   (data_data_ok),
    .cnt   (outst_cnt)
  );

  mem_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_drop_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .dec   (data_drop),
    .cnt   (drop_cnt)
  );

endmodule
